// File: rtl/axa_undo_stack_pkg.sv
// Shared AXA definitions used by the undo stack: word/pointer sizing and
// the operand type that reads from the undo stack.
package axa_undo_stack_pkg;

    localparam int WORD  = 16;
    localparam int UPTR  = 4;
    localparam int USIZE = 1 << UPTR;

    typedef enum logic [1:0] {
        ILTypeReg = 2'd0,
        ILTypeImm = 2'd1,
        ILTypeUnd = 2'd2
    } il_type_e;

endpackage

// File: rtl/axa_undo_ram.sv
// Undo stack storage: one synchronous write port, two asynchronous read ports.
// Contents are deliberately not reset.
module axa_undo_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PW-1:0]    pop_addr_i,
    output logic [WIDTH-1:0] pop_rdata_o,
    input  logic [PW-1:0]    peek_addr_i,
    output logic [WIDTH-1:0] peek_rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign pop_rdata_o  = mem_q[pop_addr_i];
    assign peek_rdata_o = mem_q[peek_addr_i];

endmodule

// File: rtl/axa_undo_stack.sv
// Circular undo stack for reverse execution: pushes overwrite the oldest
// entry when full, pops return a registered word one cycle later.
module axa_undo_stack
    import axa_undo_stack_pkg::*;
#(
    parameter int WIDTH = WORD,
    parameter int DEPTH = USIZE,
    parameter int PW    = UPTR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    input  logic [PW-1:0]    peek_off,
    output logic [WIDTH-1:0] peek_data,
    output logic             peek_valid,
    output logic [PW-1:0]    usp,
    output logic [PW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf,
    input  logic             clr_err
);

    logic [PW-1:0]    usp_q, usp_d;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic             pop_valid_q, pop_valid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             empty_w, full_w, pop_acc;
    logic [PW-1:0]    top_addr, peek_addr, waddr;
    logic [WIDTH-1:0] pop_rdata;
    logic             we;

    assign empty_w  = (count_q == '0);
    assign full_w   = (count_q == (PW+1)'(DEPTH));
    assign pop_acc  = pop && !empty_w;
    assign top_addr = usp_q - PW'(1);
    assign peek_addr = usp_q - peek_off - PW'(1);

    // A push paired with an accepted pop replaces the top in place.
    assign we    = push;
    assign waddr = (push && pop_acc) ? top_addr : usp_q;

    axa_undo_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .PW   (PW)
    ) u_ram (
        .clk         (clk),
        .we_i        (we),
        .waddr_i     (waddr),
        .wdata_i     (push_data),
        .pop_addr_i  (top_addr),
        .pop_rdata_o (pop_rdata),
        .peek_addr_i (peek_addr),
        .peek_rdata_o(peek_data)
    );

    always_comb begin
        usp_d       = usp_q;
        count_d     = count_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = pop_acc;
        ovf_d       = ovf_q && !clr_err;
        unf_d       = unf_q && !clr_err;

        if (pop_acc) pop_data_d = pop_rdata;

        if (push && !pop_acc) begin
            usp_d = usp_q + PW'(1);
            if (full_w) ovf_d = 1'b1;
            else        count_d = count_q + (PW+1)'(1);
        end else if (pop_acc && !push) begin
            usp_d   = top_addr;
            count_d = count_q - (PW+1)'(1);
        end

        if (pop && empty_w) unf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            usp_q       <= '0;
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            usp_q       <= usp_d;
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign pop_data   = pop_data_q;
    assign pop_valid  = pop_valid_q;
    assign usp        = usp_q;
    assign count      = count_q;
    assign empty      = empty_w;
    assign full       = full_w;
    assign ovf        = ovf_q;
    assign unf        = unf_q;
    assign peek_valid = ({1'b0, peek_off} < count_q);

endmodule

// File: tb/tb_axa_undo_stack.sv
// Directed bench for axa_undo_stack with hand-computed expectations.
module tb_axa_undo_stack;
    import axa_undo_stack_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        push, pop, clr_err;
    logic [15:0] push_data;
    logic [15:0] pop_data, peek_data;
    logic        pop_valid, peek_valid;
    logic [3:0]  peek_off, usp;
    logic [4:0]  count;
    logic        empty, full, ovf, unf;

    int n_chk = 0;
    int n_err = 0;

    axa_undo_stack dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .peek_off  (peek_off),
        .peek_data (peek_data),
        .peek_valid(peek_valid),
        .usp       (usp),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .ovf       (ovf),
        .unf       (unf),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        reset = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        push_data = '0; peek_off = '0;
        #12;
        chk("rst_usp", usp, 0);
        chk("rst_count", count, 0);
        chk("rst_popd", pop_data, 0);
        chk("rst_popv", pop_valid, 0);
        chk("rst_flags", {ovf, unf}, 0);
        chk("rst_empty", empty, 1);
        chk("rst_peekv", peek_valid, 0);
        reset = 1'b1;
        step();

        // Basic push of three words and peeks
        push = 1'b1; push_data = 16'h1111; step();
        push_data = 16'h2222; step();
        push_data = 16'h3333; step();
        idle();
        chk("p3_usp", usp, 3);
        chk("p3_count", count, 3);
        peek_off = 4'd0; #1;
        chk("peek0", {peek_valid, peek_data}, {1'b1, 16'h3333});
        peek_off = 4'd2; #1;
        chk("peek2", {peek_valid, peek_data}, {1'b1, 16'h1111});
        peek_off = 4'd3; #1;
        chk("peek3_v", peek_valid, 0);
        peek_off = 4'd0;

        // Three pops, each with an isolated one-cycle pop_valid
        pop = 1'b1; step(); pop = 1'b0;
        chk("pop1", {pop_valid, pop_data}, {1'b1, 16'h3333});
        step(); chk("pop1_pulse", pop_valid, 0);
        pop = 1'b1; step(); pop = 1'b0;
        chk("pop2", {pop_valid, pop_data}, {1'b1, 16'h2222});
        step(); chk("pop2_pulse", pop_valid, 0);
        pop = 1'b1; step(); pop = 1'b0;
        chk("pop3", {pop_valid, pop_data}, {1'b1, 16'h1111});
        step(); chk("pop3_pulse", pop_valid, 0);
        chk("pop_empty", empty, 1);
        chk("pop_usp", usp, 0);

        // 17 pushes wrap and overwrite the oldest entry
        push = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push_data = 16'(i);
            step();
        end
        idle();
        chk("ov_full", full, 1);
        chk("ov_ovf", ovf, 1);
        chk("ov_usp", usp, 1);
        chk("ov_count", count, 16);
        pop = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("drain%0d", i), {pop_valid, pop_data}, {1'b1, 16'(16 - i)});
        end
        pop = 1'b0;
        step();
        chk("drain_empty", {empty, pop_valid, count}, {1'b1, 1'b0, 5'd0});
        chk("drain_usp", usp, 1);

        // Underflow and error clearing
        pop = 1'b1; step(); pop = 1'b0;
        chk("unf_set", unf, 1);
        chk("unf_popv", pop_valid, 0);
        chk("unf_usp", usp, 1);
        chk("unf_popd", pop_data, 16'h0001);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("clr_flags", {ovf, unf}, 0);
        pop = 1'b1; clr_err = 1'b1; step(); idle();
        chk("set_wins", unf, 1);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("clr2", unf, 0);

        // Simultaneous push and pop with a live top
        push = 1'b1; push_data = 16'hAAAA; step(); idle();
        chk("aa_count", count, 1);
        push = 1'b1; pop = 1'b1; push_data = 16'hBBBB; step(); idle();
        chk("pp_pop", {pop_valid, pop_data}, {1'b1, 16'hAAAA});
        chk("pp_count", count, 1);
        chk("pp_usp", usp, 2);
        chk("pp_peek", {peek_valid, peek_data}, {1'b1, 16'hBBBB});

        // Simultaneous push and pop when empty: only the push happens
        pop = 1'b1; step(); idle();
        chk("pe_pre", {pop_valid, pop_data, count}, {1'b1, 16'hBBBB, 5'd0});
        push = 1'b1; pop = 1'b1; push_data = 16'hCCCC; step(); idle();
        chk("pe_popv", pop_valid, 0);
        chk("pe_unf", unf, 1);
        chk("pe_count", count, 1);
        chk("pe_usp", usp, 2);
        chk("pe_peek", {peek_valid, peek_data}, {1'b1, 16'hCCCC});

        // Reset while a popped word is being presented
        pop = 1'b1; step(); idle();
        chk("mr_popv", pop_valid, 1);
        reset = 1'b0; #1;
        chk("mr_zero", {usp, count, pop_data, pop_valid, ovf, unf}, '0);
        // A pop held across reset must not surface afterwards
        push = 1'b1; push_data = 16'hDDDD; step();
        push = 1'b0; pop = 1'b1; step();
        pop = 1'b0;
        reset = 1'b1;
        chk("mr_rel_popv", pop_valid, 0);
        step();
        chk("mr_after", {pop_valid, empty, peek_valid}, {1'b0, 1'b1, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1);
    end

endmodule
